// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with a busy scoreboard and a
// clear sequencer that runs after reset.
// Issue logic reads operands and reserves a destination register.
// Writeback writes data and releases the destination.
// Build option REGFILE_SB_BYPASS_EN selects how a read and a write to the
// same register in the same cycle are resolved:
//   - defined: write-first forwarding;
//   - undefined (default): read-before-write.
//
// state | meaning
// ------+----------------------------------------------------------
// CLEAR | zeroing one register per cycle; traffic ignored, ready low
// RUN   | normal operation; left only through reset
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    output logic                  ready_o,
    input  logic                  rd_we_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    ready_q, ready_d;
    logic [NUM_REGS-1:0]     busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   rs1_data_q, rs1_data_d;
    logic [DATA_WIDTH-1:0]   rs2_data_q, rs2_data_d;
    logic                    rs1_busy_q, rs1_busy_d;
    logic                    rs2_busy_q, rs2_busy_d;

    logic [DATA_WIDTH-1:0]   mem_q [NUM_REGS];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic                    wr_hit;
    logic                    rsv_hit;

    assign wr_hit  = rd_we_i && (rd_addr_i != '0);
    assign rsv_hit = rsv_valid_i && (rsv_addr_i != '0);

    // Next-state logic: clear sequencing, scoreboard update and read muxing.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        rs1_data_d = '0;
        rs2_data_d = '0;
        rs1_busy_d = 1'b0;
        rs2_busy_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = rd_addr_i;
        mem_wdata  = rd_data_i;

        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == ADDR_WIDTH'(NUM_REGS - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                mem_we = wr_hit;
                // Release first, then reserve, so a newer producer keeps ownership.
                if (wr_hit) busy_d[rd_addr_i] = 1'b0;
                if (rsv_hit) busy_d[rsv_addr_i] = 1'b1;

                rs1_data_d = (rs1_addr_i == '0) ? '0 : mem_q[rs1_addr_i];
                rs2_data_d = (rs2_addr_i == '0) ? '0 : mem_q[rs2_addr_i];
                rs1_busy_d = busy_q[rs1_addr_i];
                rs2_busy_d = busy_q[rs2_addr_i];
`ifdef REGFILE_SB_BYPASS_EN
                if (wr_hit && (rd_addr_i == rs1_addr_i)) begin
                    rs1_data_d = rd_data_i;
                    rs1_busy_d = rsv_hit && (rsv_addr_i == rd_addr_i);
                end
                if (wr_hit && (rd_addr_i == rs2_addr_i)) begin
                    rs2_data_d = rd_data_i;
                    rs2_busy_d = rsv_hit && (rsv_addr_i == rd_addr_i);
                end
`endif
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State, scoreboard and read-port registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_CLEAR;
            clr_ptr_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rs1_busy_q <= 1'b0;
            rs2_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rs1_busy_q <= rs1_busy_d;
            rs2_busy_q <= rs2_busy_d;
        end
    end

    // Storage has no reset; the CLEAR sequence zeroes it after every reset.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign ready_o    = ready_q;
    assign rs1_data_o = rs1_data_q;
    assign rs2_data_o = rs2_data_q;
    assign rs1_busy_o = rs1_busy_q;
    assign rs2_busy_o = rs2_busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Expected values are hand-computed.
// The REGFILE_SB_BYPASS_EN build selects the forwarding expectations.
module tb_regfile_sb;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ready_o;
    logic        rd_we_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] rd_data_i;
    logic        rsv_valid_i;
    logic [4:0]  rsv_addr_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        rs1_busy_o;
    logic        rs2_busy_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt;

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .ready_o     (ready_o),
        .rd_we_i     (rd_we_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_i   (rd_data_i),
        .rsv_valid_i (rsv_valid_i),
        .rsv_addr_i  (rsv_addr_i),
        .rs1_addr_i  (rs1_addr_i),
        .rs2_addr_i  (rs2_addr_i),
        .rs1_data_o  (rs1_data_o),
        .rs2_data_o  (rs2_data_o),
        .rs1_busy_o  (rs1_busy_o),
        .rs2_busy_o  (rs2_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        cnt = 0;
        while (!ready_o && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        rst_n_i     = 1'b0;
        rd_we_i     = 1'b0;
        rd_addr_i   = '0;
        rd_data_i   = '0;
        rsv_valid_i = 1'b0;
        rsv_addr_i  = '0;
        rs1_addr_i  = '0;
        rs2_addr_i  = '0;

        // Reset for 3 cycles, then time the clear sequence.
        repeat (3) step();
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_rs1_data", rs1_data_o, 32'd0);
        chk("rst_rs1_busy", {31'd0, rs1_busy_o}, 32'd0);
        rst_n_i = 1'b1;
        wait_ready();
        chk("clear_len", cnt, 32'd32);

        // Write x5 and read it back on both ports.
        rd_we_i = 1'b1; rd_addr_i = 5'd5; rd_data_i = 32'hDEADBEEF;
        step();
        rd_we_i = 1'b0; rs1_addr_i = 5'd5; rs2_addr_i = 5'd5;
        step();
        chk("x5_rs1", rs1_data_o, 32'hDEADBEEF);
        chk("x5_rs2", rs2_data_o, 32'hDEADBEEF);

        // x0 ignores writes and reserves.
        rd_we_i = 1'b1; rd_addr_i = 5'd0; rd_data_i = 32'h12345678;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd0;
        step();
        rd_we_i = 1'b0; rsv_valid_i = 1'b0; rs1_addr_i = 5'd0;
        step();
        chk("x0_data", rs1_data_o, 32'd0);
        chk("x0_busy", {31'd0, rs1_busy_o}, 32'd0);

        // Reserve x7, then release it by a write.
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd7;
        step();
        rsv_valid_i = 1'b0; rs1_addr_i = 5'd7;
        step();
        chk("x7_rsv_busy", {31'd0, rs1_busy_o}, 32'd1);
        chk("x7_rsv_data", rs1_data_o, 32'd0);
        rd_we_i = 1'b1; rd_addr_i = 5'd7; rd_data_i = 32'hA5A5A5A5;
        step();
        rd_we_i = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        chk("x7_wr_same_data", rs1_data_o, 32'hA5A5A5A5);
        chk("x7_wr_same_busy", {31'd0, rs1_busy_o}, 32'd0);
`else
        chk("x7_wr_same_data", rs1_data_o, 32'd0);
        chk("x7_wr_same_busy", {31'd0, rs1_busy_o}, 32'd1);
`endif
        step();
        chk("x7_rel_busy", {31'd0, rs1_busy_o}, 32'd0);
        chk("x7_rel_data", rs1_data_o, 32'hA5A5A5A5);

        // Same-cycle reserve and write of x9: reserve wins.
        rd_we_i = 1'b1; rd_addr_i = 5'd9; rd_data_i = 32'h00000099;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd9;
        step();
        rd_we_i = 1'b0; rsv_valid_i = 1'b0; rs2_addr_i = 5'd9;
        step();
        chk("x9_busy", {31'd0, rs2_busy_o}, 32'd1);
        chk("x9_data", rs2_data_o, 32'h00000099);

        // A reserve is not visible on a read issued in the same cycle.
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd11; rs1_addr_i = 5'd11;
        step();
        rsv_valid_i = 1'b0;
        chk("x11_same_busy", {31'd0, rs1_busy_o}, 32'd0);
        step();
        chk("x11_next_busy", {31'd0, rs1_busy_o}, 32'd1);

        // x3: old 0x1 and busy, then a write of 0x2 with both ports reading x3.
        rd_we_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'h1;
        step();
        rd_we_i = 1'b0; rsv_valid_i = 1'b1; rsv_addr_i = 5'd3;
        step();
        rsv_valid_i = 1'b0;
        rd_we_i = 1'b1; rd_addr_i = 5'd3; rd_data_i = 32'h2;
        rs1_addr_i = 5'd3; rs2_addr_i = 5'd3;
        step();
        rd_we_i = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
        chk("x3_rs1_data", rs1_data_o, 32'h2);
        chk("x3_rs2_data", rs2_data_o, 32'h2);
        chk("x3_rs1_busy", {31'd0, rs1_busy_o}, 32'd0);
`else
        chk("x3_rs1_data", rs1_data_o, 32'h1);
        chk("x3_rs2_data", rs2_data_o, 32'h1);
        chk("x3_rs1_busy", {31'd0, rs1_busy_o}, 32'd1);
`endif
        step();
        chk("x3_after_data", rs1_data_o, 32'h2);
        chk("x3_after_busy", {31'd0, rs2_busy_o}, 32'd0);

        // Reset, then reset again when clr_ptr reaches 10.
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        repeat (10) step();
        chk("mid_clear_ready", {31'd0, ready_o}, 32'd0);
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;

        // Traffic during CLEAR must be ignored; read outputs are forced to 0.
        rd_we_i = 1'b1; rd_addr_i = 5'd4; rd_data_i = 32'hFFFFFFFF;
        rsv_valid_i = 1'b1; rsv_addr_i = 5'd4;
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd9;
        step();
        chk("clr_rs1_forced", rs1_data_o, 32'd0);
        chk("clr_rs2_busy_forced", {31'd0, rs2_busy_o}, 32'd0);
        wait_ready();
        chk("reclear_len", cnt + 1, 32'd32);
        rd_we_i = 1'b0; rsv_valid_i = 1'b0;

        // Every register reads 0 and not busy after the clear.
        for (int i = 1; i < 32; i++) begin
            rs1_addr_i = 5'(i);
            rs2_addr_i = 5'(i);
            step();
            chk($sformatf("clr_x%0d_data", i), rs1_data_o, 32'd0);
            chk($sformatf("clr_x%0d_busy", i), {30'd0, rs1_busy_o, rs2_busy_o}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
